adder_operand_feeder: RTL

Operand-buffering stage that sits directly upstream of the 4-bit `adder`. It accepts (a, b) operand pairs from a producer over a valid/ready handshake and queues them in a small FIFO. It then drives the adder's `a`, `b` and `valid` inputs with the alternating pattern the adder needs: `valid` high for one cycle latches `sum`, and `valid` low for the next cycle publishes `sum` to `c`. It flags the cycle in which the adder's `c` holds each new result.

---
 rtl/adder_operand_feeder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/adder_operand_feeder.sv
// adder_operand_feeder: queues (a, b) operand pairs from a valid/ready producer
// and drives a downstream 4-bit adder with the valid=1 (latch sum) /
// valid=0 (publish c) pattern, flagging the cycle in which c holds a new result.
module adder_operand_feeder #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        a,
  output logic [DATA_W-1:0]        b,
  output logic                     valid,
  output logic                     result_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               issue_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // IDLE: nothing in flight; DRIVE: adder latches sum; PUBLISH: adder copies sum to c
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                valid_q, valid_d;
  logic                result_valid_q, result_valid_d;
  logic [7:0]          issue_cnt_q, issue_cnt_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic                push;
  logic                pop;

  // Ready only when out of reset and a slot is free; no bypass of a same-cycle pop.
  assign in_ready = !reset && (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  // Next-state, FIFO bookkeeping and operand load for the issue handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    a_d            = a_q;
    b_d            = b_q;
    valid_d        = 1'b0;
    result_valid_d = 1'b0;
    issue_cnt_d    = issue_cnt_q;
    pop            = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = PUBLISH;
      end
      PUBLISH: begin
        result_valid_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      {a_d, b_d}  = mem_q[rd_ptr_q];
      valid_d     = 1'b1;
      issue_cnt_d = issue_cnt_q + 8'd1;
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      valid_q        <= 1'b0;
      result_valid_q <= 1'b0;
      issue_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      a_q            <= a_d;
      b_q            <= b_d;
      valid_q        <= valid_d;
      result_valid_q <= result_valid_d;
      issue_cnt_q    <= issue_cnt_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptying the pointers and count is
    // enough, since a slot is never read before it has been written.
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign valid        = valid_q;
  assign result_valid = result_valid_q;
  assign count        = count_q;
  assign issue_cnt    = issue_cnt_q;

endmodule
